logic_unit_32_bits: RTL and testbench
=====================================

# logic_unit_32_bits

Sequential 32-bit bitwise logic unit (NOT, AND, OR, XOR) with valid/ready handshakes on both sides. It processes operands in SLICE-bit slices, one slice per cycle, and holds the result until the consumer accepts it. It sits in the datapath components set beside the combinational `not_32_bits`. It answers requests from the control/ALU sequencer and returns the result in the form the benches already check: `S` compared against the expected bitwise complement or logic value.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `SLICE`, 8: bits processed per cycle. WIDTH must be an integer multiple of SLICE. N = WIDTH/SLICE (4 by default).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  2  operation: 00 = NOT A, 01 = A AND B, 10 = A OR B, 11 = A XOR B.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B; ignored for NOT.
- `out_valid`  out  1  result `S` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `S`  out  WIDTH  result register.
- `zero`  out  1  high when `out_valid` is high and S == 0; 0 otherwise.

## Operation
- FSM states: IDLE, BUSY, DONE. Slice counter `cnt` is ceil(log2 N) bits wide.
- **IDLE:**
  - `in_ready` = 1 and `out_valid` = 0.
  - An edge with `in_valid` = 1 is the accept. On accept, latch A, B and op; clear S to 0; set `cnt` = 0; move to BUSY.
- **BUSY:**
  - `in_ready` = 0 and `out_valid` = 0.
  - Each edge computes slice `cnt` (bits [cnt*SLICE +: SLICE]) from the latched operands and writes it into S. `cnt` then increments.
  - After the edge that writes slice N-1, move to DONE.
- **DONE:**
  - `out_valid` = 1. S and `zero` are stable.
  - An edge with `out_ready` = 1 returns the FSM to IDLE.
  - A new request cannot be accepted in the same cycle as `out_ready`; the earliest accept is the following cycle.
- The unit computes only from the latched operands. Changes on A, B or op after the accept edge have no effect.
- `in_valid` while the FSM is in BUSY or DONE is ignored; nothing is latched.
- The result is pure bitwise logic: no carry, no sign handling, no width change.

## Timing
- Reset values, in the cycle after any edge with `reset` = 1:
  - state = IDLE, `cnt` = 0, S = 0.
  - `out_valid` = 0, `zero` = 0.
  - `in_ready` = 0 while `reset` is high; 1 in the first cycle after `reset` is low.
- Reset takes priority over every other event.
  - Reset in BUSY or DONE abandons the operation: `out_valid` never asserts for it and S clears.
- Latency: with the accept at edge k, `out_valid` is first high in the cycle following edge k+N (4 cycles for the defaults).
- Throughput: one operation per N+2 cycles when `out_ready` is held high.
- Backpressure: `out_valid` and S hold indefinitely while `out_ready` = 0.
- `out_ready` outside DONE has no effect.
- Outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- Reset, then NOT on A=0x00000000:
  - `in_ready` goes high one cycle after reset deasserts.
  - `out_valid` rises exactly 4 cycles after the accept edge with S=0xFFFFFFFF and `zero`=0.
- Back-to-back NOTs with `out_ready` held high:
  - A=0x80000001 gives S=0x7FFFFFFE.
  - A=0xC0000001 gives S=0x3FFFFFFE.
  - A=0x00000003 gives S=0xFFFFFFFC.
  - Accepts are 6 cycles apart.
- NOT on A=0xFFFFFFFF, then AND on A=0xF0F0F0F0, B=0x0F0F0F0F:
  - Both give S=0x00000000 with `zero`=1.
  - Then XOR on A=0x12345678, B=0xFFFFFFFF gives S=0xEDCBA987 with `zero`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - S and `out_valid` stay stable.
  - A new `in_valid` with different A during this window is not accepted: `in_ready`=0.
- Operand change: change A to 0x00000000 one cycle after accepting OR with A=0xAAAA0000, B=0x00005555.
  - S=0xAAAA5555.
- Reset mid-operation: assert `reset` for one cycle, two cycles after an accept.
  - `out_valid` stays 0, S=0, and the unit accepts the next request normally.

Source files
------------

// File: rtl/logic_unit_32_bits.sv
// Sequential bitwise logic unit (NOT/AND/OR/XOR) computing SLICE bits per cycle,
// with valid/ready handshakes on request and result sides.
`timescale 1ns/1ps
module logic_unit_32_bits #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             zero
);

   localparam int unsigned N    = WIDTH / SLICE;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [1:0]        op_q;
   logic [WIDTH-1:0]  s_q;

   logic [31:0]       base;
   logic [SLICE-1:0]  a_sl;
   logic [SLICE-1:0]  b_sl;
   logic [SLICE-1:0]  r_sl;

   // Current slice is selected from the latched operands only.
   always_comb begin
      base = 32'(cnt_q) * SLICE;
      a_sl = a_q[base +: SLICE];
      b_sl = b_q[base +: SLICE];
      r_sl = '0;
      unique case (op_q)
         2'b00:   r_sl = ~a_sl;
         2'b01:   r_sl = a_sl & b_sl;
         2'b10:   r_sl = a_sl | b_sl;
         2'b11:   r_sl = a_sl ^ b_sl;
         default: r_sl = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         s_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= A;
                  b_q     <= B;
                  op_q    <= op;
                  s_q     <= '0;
                  cnt_q   <= '0;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               s_q[base +: SLICE] <= r_sl;
               cnt_q              <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // in_ready is masked by reset so no request is taken while reset is held.
   assign in_ready  = (state_q == StIdle) && !reset;
   assign out_valid = (state_q == StDone);
   assign S         = s_q;
   assign zero      = (state_q == StDone) && (s_q == '0);

endmodule

// File: tb/tb_logic_unit_32_bits.sv
// Scoreboard bench for logic_unit_32_bits: driver pushes expected results,
// monitor pops and compares on every result handshake.
`timescale 1ns/1ps
module tb_logic_unit_32_bits;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SLICE = 8;
   localparam int N = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] S;
   logic             zero;

   logic_unit_32_bits #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             z;
      int               acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_acc = 0;
   bit   rand_rdy = 1'b0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (o)
         2'd0:    return ~a;
         2'd1:    return a & b;
         2'd2:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Present a request and hold it until accepted; record expected result.
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
      exp_t e;
      bit   done = 1'b0;
      in_valid = 1'b1;
      op = o;
      A = a;
      B = b;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.s = model(o, a, b);
            e.z = (e.s == '0);
            e.acc = cyc + 1;
            exp_q.push_back(e);
            last_acc = e.acc;
            done = 1'b1;
         end
      end
      if (!done) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      op = 2'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency on first valid cycle, value/zero every valid cycle, pop on handshake.
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(exp_q.size()), 64'd1);
         end else begin
            if (!prev_valid) check("latency", 64'(cyc - exp_q[0].acc), 64'(N));
            check("S", 64'(S), 64'(exp_q[0].s));
            check("zero", 64'(zero), 64'(exp_q[0].z));
            if (out_ready) void'(exp_q.pop_front());
         end
      end else begin
         check("zero_idle", 64'(zero), 64'd0);
      end
      prev_valid = out_valid;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a1, a2, a3;
      logic [WIDTH-1:0] held;
      bit seen;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_S", 64'(S), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // NOT of zero
      out_ready = 1'b1;
      issue(2'd0, 32'h0000_0000, $urandom);
      drain();

      // Back-to-back NOTs
      issue(2'd0, 32'h8000_0001, $urandom);
      a1 = last_acc;
      issue(2'd0, 32'hC000_0001, $urandom);
      a2 = last_acc;
      issue(2'd0, 32'h0000_0003, $urandom);
      a3 = last_acc;
      check("b2b_gap1", 64'(a2 - a1), 64'd6);
      check("b2b_gap2", 64'(a3 - a2), 64'd6);
      drain();

      // Zero results then XOR
      issue(2'd0, 32'hFFFF_FFFF, $urandom);
      issue(2'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
      issue(2'd3, 32'h1234_5678, 32'hFFFF_FFFF);
      drain();

      // Backpressure in DONE with a competing request
      out_ready = 1'b0;
      issue(2'($urandom), $urandom, $urandom);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("bp_reach_done", 64'(out_valid), 64'd1);
      held = S;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         A = ~held;
         @(negedge clk);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_S_stable", 64'(S), 64'(held));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Operand change after accept
      issue(2'd2, 32'hAAAA_0000, 32'h0000_5555);
      A = 32'h0000_0000;
      drain();

      // Reset two cycles after an accept
      issue(2'($urandom), $urandom, $urandom);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_out_valid", 64'(out_valid), 64'd0);
         check("abort_S", 64'(S), 64'd0);
      end
      @(posedge clk);
      #1;
      issue(2'd3, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
      drain();

      // Randomized operations with random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom), $urandom, (i % 7 == 0) ? 32'($urandom) : 32'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            A = $urandom;
         end
      end
      drain();
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
